debounce_multi: RTL and testbench

//   Parametrised N-channel push-button debouncer; successor to the single-channel debounce.
//   Per channel: 2-FF synchroniser, stable-time filter, clean level output, one-cycle

---
 rtl/debounce_multi.sv | 146 ++++++++++++++
 tb/tb_debounce_multi.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// N-channel push-button debouncer: 2-FF synchroniser, stable-time filter, press/release pulses,
// long-press detection and auto-repeat. The release pulse port is release_pulse ("release" is reserved).
module debounce_multi #(
    parameter int N_CH          = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int LONG_CYCLES   = 32,
    parameter int REPEAT_CYCLES = 16,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [N_CH-1:0] button,
    output logic [N_CH-1:0] signal,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_press,
    output logic [N_CH-1:0] repeat_tick
);

    localparam int CNT_W  = $clog2(STABLE_CYCLES);
    localparam int HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam int REP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam bit REP_EN = (REPEAT_CYCLES > 0);

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_MAX  = REP_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, HOLD, LONG} hold_state_t;

    function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] v);
        return (v == HOLD_MAX) ? v : v + HOLD_W'(1);
    endfunction

    function automatic logic [REP_W-1:0] rep_wrap_inc(input logic [REP_W-1:0] v);
        return (v == REP_MAX) ? '0 : v + REP_W'(1);
    endfunction

    logic [N_CH-1:0] sync_p1, sync_p2;

    // Stage p1/p2: two-flop synchroniser after polarity correction
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_p1 <= '0;
            sync_p2 <= '0;
        end else begin
            sync_p1 <= button ^ {N_CH{ACTIVE_LOW}};
            sync_p2 <= sync_p1;
        end
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [CNT_W-1:0]  cnt, cnt_nxt;
        logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
        logic [REP_W-1:0]  rep_cnt, rep_cnt_nxt;
        hold_state_t       state, state_nxt;
        logic sig_q, sig_nxt;
        logic press_q, press_nxt, rel_q, rel_nxt;
        logic long_q, long_nxt, tick_q, tick_nxt;

        always_comb begin
            cnt_nxt   = '0;
            sig_nxt   = sig_q;
            press_nxt = 1'b0;
            rel_nxt   = 1'b0;
            if (sync_p2[ch] != sig_q) begin
                if (cnt == CNT_MAX) begin
                    sig_nxt   = sync_p2[ch];
                    press_nxt = sync_p2[ch];
                    rel_nxt   = !sync_p2[ch];
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
        end

        // Hold FSM follows the next debounced level so a release beats a due long_press
        always_comb begin
            state_nxt    = state;
            hold_cnt_nxt = hold_cnt;
            rep_cnt_nxt  = rep_cnt;
            long_nxt     = 1'b0;
            tick_nxt     = 1'b0;
            if (!sig_nxt) begin
                state_nxt    = IDLE;
                hold_cnt_nxt = '0;
                rep_cnt_nxt  = '0;
            end else begin
                case (state)
                    IDLE: begin
                        state_nxt    = HOLD;
                        hold_cnt_nxt = '0;
                    end
                    HOLD: begin
                        if (hold_cnt == HOLD_MAX) begin
                            long_nxt    = 1'b1;
                            state_nxt   = LONG;
                            rep_cnt_nxt = '0;
                        end else begin
                            hold_cnt_nxt = hold_sat_inc(hold_cnt);
                        end
                    end
                    LONG: begin
                        if (REP_EN) begin
                            tick_nxt    = (rep_cnt == REP_MAX);
                            rep_cnt_nxt = rep_wrap_inc(rep_cnt);
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end

        // Stage p3: filter, hold FSM and registered pulses
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                cnt      <= '0;
                sig_q    <= 1'b0;
                press_q  <= 1'b0;
                rel_q    <= 1'b0;
                state    <= IDLE;
                hold_cnt <= '0;
                rep_cnt  <= '0;
                long_q   <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                cnt      <= cnt_nxt;
                sig_q    <= sig_nxt;
                press_q  <= press_nxt;
                rel_q    <= rel_nxt;
                state    <= state_nxt;
                hold_cnt <= hold_cnt_nxt;
                rep_cnt  <= rep_cnt_nxt;
                long_q   <= long_nxt;
                tick_q   <= tick_nxt;
            end
        end

        assign signal[ch]        = sig_q;
        assign press[ch]         = press_q;
        assign release_pulse[ch] = rel_q;
        assign long_press[ch]    = long_q;
        assign repeat_tick[ch]   = tick_q;
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: an active-high instance and an ACTIVE_LOW instance.
module tb_debounce_multi;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [N-1:0] btn_a, btn_b;
    logic [N-1:0] sig_a, prs_a, rel_a, lng_a, rep_a;
    logic [N-1:0] sig_b, prs_b, rel_b, lng_b, rep_b;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int cyc;
        int code;
    } ev_t;
    ev_t q[$];

    // kind: 0 press, 1 release, 2 long_press, 3 repeat_tick; dut: 0 active-high, 1 active-low
    function automatic int ev_code(input int kind, input int dut, input int ch);
        return kind * (2 * N) + dut * N + ch;
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    debounce_multi #(.N_CH(N), .STABLE_CYCLES(8), .LONG_CYCLES(32), .REPEAT_CYCLES(16),
                     .ACTIVE_LOW(1'b0)) dut_a (
        .clock(clk), .reset_n(reset_n), .button(btn_a), .signal(sig_a), .press(prs_a),
        .release_pulse(rel_a), .long_press(lng_a), .repeat_tick(rep_a));

    debounce_multi #(.N_CH(N), .STABLE_CYCLES(8), .LONG_CYCLES(32), .REPEAT_CYCLES(16),
                     .ACTIVE_LOW(1'b1)) dut_b (
        .clock(clk), .reset_n(reset_n), .button(btn_b), .signal(sig_b), .press(prs_b),
        .release_pulse(rel_b), .long_press(lng_b), .repeat_tick(rep_b));

    // Monitor: every pulse seen must match the oldest expected event
    always @(negedge clk) begin
        logic [N-1:0] v;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                case (k)
                    0: v = d ? prs_b : prs_a;
                    1: v = d ? rel_b : rel_a;
                    2: v = d ? lng_b : lng_a;
                    default: v = d ? rep_b : rep_a;
                endcase
                for (int c = 0; c < N; c++) begin
                    if (v[c]) begin
                        checks++;
                        if (q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_pulse: code %0d at cycle %0d, none expected",
                                     ev_code(k, d, c), cyc);
                        end else begin
                            ev_t e;
                            e = q.pop_front();
                            if (e.cyc != cyc || e.code != ev_code(k, d, c)) begin
                                errors++;
                                $display("FAIL pulse_event: got code %0d at cycle %0d, expected code %0d at cycle %0d",
                                         ev_code(k, d, c), cyc, e.code, e.cyc);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic expect_ev(input int c, input int kind, input int dut, input int ch);
        ev_t e;
        e.cyc  = c;
        e.code = ev_code(kind, dut, ch);
        q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int t, e0;
        btn_a = '0;
        btn_b = '1;
        step(2);
        chk("reset_signal_a", int'(sig_a), 0);
        chk("reset_press_a", int'(prs_a), 0);
        chk("reset_release_a", int'(rel_a), 0);
        chk("reset_long_a", int'(lng_a), 0);
        chk("reset_repeat_a", int'(rep_a), 0);
        chk("reset_signal_b", int'(sig_b), 0);
        reset_n = 1'b1;
        step(3);

        // Test 1: toggling every cycle never passes the filter
        for (int i = 0; i < 13; i++) begin
            btn_a[0] = (i % 2 == 0);
            step(1);
        end
        btn_a[0] = 1'b0;
        step(20);
        chk("bounce_only_signal", int'(sig_a), 0);

        // Test 2: bounce then steady high
        for (int i = 0; i < 13; i++) begin
            btn_a[0] = (i % 2 == 0);
            if (i < 12) step(1);
        end
        t = cyc;
        expect_ev(t + 10, 0, 0, 0);
        step(9);
        chk("ch0_not_yet_at_9", int'(sig_a), 0);
        step(1);
        chk("ch0_signal_at_10", int'(sig_a), 1);
        wait_until(t + 15);
        btn_a[0] = 1'b0;
        expect_ev(cyc + 10, 1, 0, 0);
        step(12);
        chk("ch0_released", int'(sig_a), 0);

        // Test 3: ch1 held 100 cycles -> long press and four repeats
        btn_a[1] = 1'b1;
        t = cyc;
        e0 = t + 10;
        expect_ev(e0, 0, 0, 1);
        expect_ev(e0 + 32, 2, 0, 1);
        for (int r = 48; r <= 96; r += 16) expect_ev(e0 + r, 3, 0, 1);
        wait_until(e0 + 100);
        chk("ch1_held", int'(sig_a), 2);
        btn_a[1] = 1'b0;
        expect_ev(e0 + 110, 1, 0, 1);
        wait_until(e0 + 115);
        chk("ch1_released", int'(sig_a), 0);

        // Test 4: ch2 short hold -> no long press
        btn_a[2] = 1'b1;
        t = cyc;
        expect_ev(t + 10, 0, 0, 2);
        wait_until(t + 20);
        btn_a[2] = 1'b0;
        expect_ev(t + 30, 1, 0, 2);
        wait_until(t + 45);

        // Release lands on the long_press edge: release wins
        btn_a[2] = 1'b1;
        e0 = cyc + 10;
        expect_ev(e0, 0, 0, 2);
        wait_until(e0 + 22);
        btn_a[2] = 1'b0;
        expect_ev(e0 + 32, 1, 0, 2);
        wait_until(e0 + 50);
        chk("ch2_tie_released", int'(sig_a), 0);

        // One edge later: long_press fires, then release
        btn_a[2] = 1'b1;
        e0 = cyc + 10;
        expect_ev(e0, 0, 0, 2);
        wait_until(e0 + 23);
        btn_a[2] = 1'b0;
        expect_ev(e0 + 32, 2, 0, 2);
        expect_ev(e0 + 33, 1, 0, 2);
        wait_until(e0 + 50);

        // Test 5: reset while ch3 held
        btn_a[3] = 1'b1;
        t = cyc;
        expect_ev(t + 10, 0, 0, 3);
        wait_until(t + 15);
        chk("ch3_held_before_reset", int'(sig_a), 8);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_signal_a", int'(sig_a), 0);
        chk("rst_press_a", int'(prs_a), 0);
        chk("rst_release_a", int'(rel_a), 0);
        chk("rst_long_a", int'(lng_a), 0);
        chk("rst_repeat_a", int'(rep_a), 0);
        step(2);
        reset_n = 1'b1;
        t = cyc;
        expect_ev(t + 10, 0, 0, 3);
        step(9);
        chk("ch3_not_yet_after_reset", int'(sig_a), 0);
        wait_until(t + 15);
        btn_a[3] = 1'b0;
        expect_ev(cyc + 10, 1, 0, 3);
        step(15);

        // Test 6: active-low instance, idle-high buttons
        chk("b_idle_signal", int'(sig_b), 0);
        btn_b[0] = 1'b0;
        t = cyc;
        expect_ev(t + 10, 0, 1, 0);
        step(10);
        chk("b_ch0_pressed", int'(sig_b), 1);
        btn_b[0] = 1'b1;
        expect_ev(cyc + 10, 1, 1, 0);
        step(15);
        chk("b_ch0_released", int'(sig_b), 0);

        step(5);
        chk("events_outstanding", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
